// File: rtl/cell_pos_reader_if.sv
// ---------------------------------------------------------------------------
// cell_pos_reader_if
//   Bus bundle for the cell position reader: the read port of the cell RAM
//   and the valid/ready particle stream toward the filters.
//   master : reader side (drives RAM address/enables and the output stream)
//   slave  : environment side (RAM returns ram_q, sink drives out_ready)
//   Signals:
//     ram_addr  RAM address           ram_rden  RAM read enable
//     ram_wren  RAM write enable      ram_q     RAM read data (2-cycle latency)
//     out_valid beat valid            out_ready downstream accept
//     out_pos   {posz,posy,posx}      out_pid   particle index 1..N
//     out_last  beat is particle N
// ---------------------------------------------------------------------------
interface cell_pos_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_rden;
  logic                  ram_wren;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pos;
  logic [ADDR_WIDTH-1:0] out_pid;
  logic                  out_last;

  modport master (
    output ram_addr, ram_rden, ram_wren,
    input  ram_q,
    output out_valid, out_pos, out_pid, out_last,
    input  out_ready
  );

  modport slave (
    input  ram_addr, ram_rden, ram_wren,
    output ram_q,
    input  out_valid, out_pos, out_pid, out_last,
    output out_ready
  );
endinterface

// File: rtl/cell_pos_reader.sv
// ---------------------------------------------------------------------------
// cell_pos_reader
//   Read-side initiator for one cell position RAM. On start it reads the
//   particle count from address 0, then streams words 1..N out over a
//   valid/ready interface with full backpressure. Reads are only issued while
//   the output FIFO has room for everything already in flight, so RAM data is
//   never dropped.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           begin a cell read (honoured only when idle)
//     busy            cell in progress (CNT_REQ .. DONE)
//     cell_done       1-cycle pulse once the last beat has been accepted
//     particle_count  clamped count of the current/last cell
//     bus             RAM read port and output stream (master modport)
// ---------------------------------------------------------------------------
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  cell_done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  cell_pos_reader_if.master     bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = OCC_W + 2;
  localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, DONE
  } state_t;

  // Saturate the raw RAM count to the physical RAM depth.
  function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
    return (raw > MAX_CNT) ? MAX_CNT : raw;
  endfunction

  // FIFO pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t                state_q, state_d;
  logic                  wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] next_pid_q, next_pid_d;
  logic                  ram_rden_q, ram_rden_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;

  logic                  vld_p0;
  logic                  vld_p1_q, vld_p2_q;
  logic [ADDR_WIDTH-1:0] pid_p1_q, pid_p2_q;
  logic                  last_p1_q, last_p2_q;

  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      occ_q, occ_next;
  logic [ENT_W-1:0]      head;

  logic                  push, pop, out_valid_w;
  logic [CR_W-1:0]       credit_used;
  logic                  credit_ok, drained;

  // Stage p0: the registered RAM request itself. Address 0 is the count
  // read and never enters the data path.
  assign vld_p0      = ram_rden_q && (ram_addr_q != '0);
  assign push        = vld_p2_q;
  assign out_valid_w = (occ_q != '0);
  assign pop         = out_valid_w && bus.out_ready;
  assign occ_next    = occ_q + OCC_W'(push) - OCC_W'(pop);

  // Entries the FIFO must still hold after this edge: buffered beats plus
  // reads that are still in the RAM pipeline. A new read is allowed only if
  // it also fits.
  assign credit_used = CR_W'(occ_next) + CR_W'(vld_p0) + CR_W'(vld_p1_q);
  assign credit_ok   = credit_used < CR_W'(FIFO_DEPTH);
  assign drained     = !vld_p0 && !vld_p1_q && (occ_next == '0);

  always_comb begin
    state_d    = state_q;
    wait_d     = 1'b0;
    cnt_d      = cnt_q;
    next_pid_d = next_pid_q;
    ram_rden_d = 1'b0;
    ram_addr_d = ram_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CNT_REQ;
          ram_rden_d = 1'b1;
          ram_addr_d = '0;
        end
      end
      CNT_REQ: state_d = CNT_WAIT;
      CNT_WAIT: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          // Count arrives now; addr 1 is issued straight away so the first
          // data read lands in the first STREAM cycle.
          cnt_d = clamp_count(bus.ram_q[ADDR_WIDTH-1:0]);
          if (cnt_d == '0) begin
            state_d = DONE;
          end else begin
            ram_rden_d = 1'b1;
            ram_addr_d = ADDR_WIDTH'(1);
            next_pid_d = ADDR_WIDTH'(2);
            state_d    = (cnt_d == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
          end
        end
      end
      STREAM: begin
        if (credit_ok) begin
          ram_rden_d = 1'b1;
          ram_addr_d = next_pid_q;
          next_pid_d = next_pid_q + 1'b1;
          if (next_pid_q == cnt_q) state_d = DRAIN;
        end
      end
      DRAIN: if (drained) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= 1'b0;
      cnt_q      <= '0;
      next_pid_q <= '0;
      ram_rden_q <= 1'b0;
      ram_addr_q <= '0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      next_pid_q <= next_pid_d;
      ram_rden_q <= ram_rden_d;
      ram_addr_q <= ram_addr_d;
      // Stage p0 -> p1 -> p2: tag follows the read through the RAM latency
      vld_p1_q   <= vld_p0;
      vld_p2_q   <= vld_p1_q;
      if (push) wr_ptr_q <= inc_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= inc_ptr(rd_ptr_q);
      occ_q      <= occ_next;
    end
  end

  always_ff @(posedge clk) begin
    // Stage p0 -> p1
    pid_p1_q  <= ram_addr_q;
    last_p1_q <= (ram_addr_q == cnt_q);
    // Stage p1 -> p2
    pid_p2_q  <= pid_p1_q;
    last_p2_q <= last_p1_q;
    // Stage p2: ram_q lines up with its tag here
    if (push) mem_q[wr_ptr_q] <= {last_p2_q, pid_p2_q, bus.ram_q};
  end

  assign head = mem_q[rd_ptr_q];

  // Gating with valid keeps the payload at zero whenever the FIFO is empty,
  // including straight after reset, without resetting the storage.
  assign bus.out_valid = out_valid_w;
  assign bus.out_pos   = out_valid_w ? head[DATA_WIDTH-1:0] : '0;
  assign bus.out_pid   = out_valid_w ? head[DATA_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.out_last  = out_valid_w && head[ENT_W-1];
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_rden  = ram_rden_q;
  assign bus.ram_wren  = 1'b0;

  assign busy           = (state_q != IDLE);
  assign cell_done      = (state_q == DONE);
  assign particle_count = cnt_q;

endmodule
